// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared types and helpers for the data-memory arbiter slice.
//   state_t   - sequencer states (IDLE, ACCESS, RESP)
//   req_id_t  - requester identifier (0 = CPU load/store, 1 = DMA/debug)
//   WIDX_HI/LO - word-index field of a byte address
//   addr_err  - alignment / range check for a byte address
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam int WIDX_HI = 13;
  localparam int WIDX_LO = 2;

  // An access is rejected when it is not word aligned, when its word index
  // falls past the populated depth, or when any bit above the index is set.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] widx;
    widx = 32'(addr[WIDX_HI:WIDX_LO]);
    return (addr[WIDX_LO-1:0] != 2'b00) ||
           (widx >= depth) ||
           (addr[31:WIDX_HI+1] != '0);
  endfunction

endpackage

// File: rtl/dm_arb_if.sv
// dm_arb_if: bundles both requester channels, both response channels and the
// single-port memory bus of the data-memory arbiter.
//   slave  modport - used by dm_arbiter (accepts requests, drives memory)
//   master modport - used by requesters / memory model
interface dm_arb_if;

  logic        rq0_valid, rq1_valid;
  logic        rq0_ready, rq1_ready;
  logic        rq0_we,    rq1_we;
  logic [31:0] rq0_addr,  rq1_addr;
  logic [31:0] rq0_wdata, rq1_wdata;
  logic [31:0] rq0_pc,    rq1_pc;

  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        rsp0_err,   rsp1_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  modport slave (
    input  rq0_valid, rq0_we, rq0_addr, rq0_wdata, rq0_pc,
    input  rq1_valid, rq1_we, rq1_addr, rq1_wdata, rq1_pc,
    input  rsp0_ready, rsp1_ready, mem_rd,
    output rq0_ready, rq1_ready,
    output rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err,
    output mem_addr, mem_wd, mem_we
  );

  modport master (
    output rq0_valid, rq0_we, rq0_addr, rq0_wdata, rq0_pc,
    output rq1_valid, rq1_we, rq1_addr, rq1_wdata, rq1_pc,
    output rsp0_ready, rsp1_ready, mem_rd,
    input  rq0_ready, rq1_ready,
    input  rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err,
    input  mem_addr, mem_wd, mem_we
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant.
//   valid_i[1:0] - request valids (bit N = requester N)
//   last_i       - requester granted most recently
//   grant_o[1:0] - one-hot grant, zero when nobody requests
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  req_id_t    last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // Contention: favour whoever did not win last time.
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter and one-access sequencer in front of the
// single-port word-addressed data memory.
//   clk, rst - clock, synchronous active-high reset
//   bus_if   - dm_arb_if.slave: two request channels (valid/ready, we, addr,
//              wdata, pc), two response channels (valid/ready, rdata, err)
//              and the memory port (mem_addr, mem_wd, mem_we, mem_rd)
// Optional build macro DM_ARB_TRACE_EN: prints each store and each rejected
// access during the ACCESS cycle.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter bit          RST_LAST    = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  dm_arb_if.slave   bus_if
);

  state_t      state_q, state_d;
  req_id_t     last_q, id_q, gid;
  logic [1:0]  grant;
  logic        we_q, err_q;
  logic [31:0] addr_q, wdata_q, pc_q, rdata_q;
  logic        rsp_ready_sel;

  rr_arb2 u_rr (
    .valid_i ({bus_if.rq1_valid, bus_if.rq0_valid}),
    .last_i  (last_q),
    .grant_o (grant)
  );

  assign gid           = grant[1];
  assign rsp_ready_sel = id_q ? bus_if.rsp1_ready : bus_if.rsp0_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: in IDLE a grant is a handshake because ready mirrors grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant != 2'b00) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (rsp_ready_sel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: everything is forced low while rst is held so a reset landing
  // in ACCESS cannot leak a write strobe into memory.
  always_comb begin
    bus_if.rq0_ready  = 1'b0;
    bus_if.rq1_ready  = 1'b0;
    bus_if.rsp0_valid = 1'b0;
    bus_if.rsp1_valid = 1'b0;
    bus_if.rsp0_rdata = '0;
    bus_if.rsp1_rdata = '0;
    bus_if.rsp0_err   = 1'b0;
    bus_if.rsp1_err   = 1'b0;
    bus_if.mem_we     = 1'b0;
    bus_if.mem_addr   = addr_q;
    bus_if.mem_wd     = wdata_q;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          bus_if.rq0_ready = grant[0];
          bus_if.rq1_ready = grant[1];
        end
        ACCESS: bus_if.mem_we = we_q & ~err_q;
        RESP: begin
          if (id_q == 1'b0) begin
            bus_if.rsp0_valid = 1'b1;
            bus_if.rsp0_rdata = rdata_q;
            bus_if.rsp0_err   = err_q;
          end else begin
            bus_if.rsp1_valid = 1'b1;
            bus_if.rsp1_rdata = rdata_q;
            bus_if.rsp1_err   = err_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Capture / response registers. addr_q and wdata_q double as the memory
  // bus drivers, so they naturally hold between transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= RST_LAST;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && grant != 2'b00) begin
        last_q  <= gid;
        id_q    <= gid;
        we_q    <= gid ? bus_if.rq1_we    : bus_if.rq0_we;
        addr_q  <= gid ? bus_if.rq1_addr  : bus_if.rq0_addr;
        wdata_q <= gid ? bus_if.rq1_wdata : bus_if.rq0_wdata;
        pc_q    <= gid ? bus_if.rq1_pc    : bus_if.rq0_pc;
        err_q   <= addr_err(gid ? bus_if.rq1_addr : bus_if.rq0_addr, DEPTH_WORDS);
      end
      if (state_q == ACCESS) begin
        rdata_q <= (we_q | err_q) ? 32'h0 : bus_if.mem_rd;
      end
    end
  end

`ifdef DM_ARB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && state_q == ACCESS) begin
      if (err_q)     $display("@%h: DM err %h", pc_q, addr_q);
      else if (we_q) $display("@%h: *%h <= %h", pc_q, addr_q, wdata_q);
    end
  end
`else
  // The captured PC only feeds the trace.
  logic unused_pc;
  assign unused_pc = ^pc_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  dm_arb_if bus ();

  dm_arbiter #(.DEPTH_WORDS(3072), .RST_LAST(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, registered write.
  logic [31:0] mem [0:3071];
  logic [11:0] widx;
  assign widx = bus.mem_addr[13:2];
  always_comb begin
    bus.mem_rd = 32'h0;
    if (widx < 12'd3072) bus.mem_rd = mem[widx];
  end
  always_ff @(posedge clk) begin
    if (bus.mem_we && widx < 12'd3072) mem[widx] <= bus.mem_wd;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise a request, wait (bounded) for ready, and return just after the
  // handshake edge with valid dropped. The caller checks ok.
  task automatic issue(input int id, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, output bit ok);
    ok = 1'b0;
    if (id == 0) begin
      bus.rq0_we = we; bus.rq0_addr = addr; bus.rq0_wdata = wdata;
      bus.rq0_pc = 32'h100 + addr; bus.rq0_valid = 1'b1;
    end else begin
      bus.rq1_we = we; bus.rq1_addr = addr; bus.rq1_wdata = wdata;
      bus.rq1_pc = 32'h200 + addr; bus.rq1_valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((id == 0 && bus.rq0_ready) || (id == 1 && bus.rq1_ready)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) step();
    if (id == 0) bus.rq0_valid = 1'b0;
    else         bus.rq1_valid = 1'b0;
  endtask

  task automatic release_rsp(input int id);
    if (id == 0) bus.rsp0_ready = 1'b1;
    else         bus.rsp1_ready = 1'b1;
    step();
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    rst = 1'b1;
    bus.rq0_valid = 1'b1;
    step();
    step();
    flags = {bus.rq0_ready, bus.rq1_ready, bus.rsp0_valid, bus.rsp1_valid,
             bus.rsp0_err, bus.rsp1_err, bus.mem_we};
    n_cmp++;
    if (flags !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000000", flags);
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_wd, bus.rsp0_rdata, bus.rsp1_rdata} !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h %h %h %h want all 0", bus.mem_addr, bus.mem_wd,
               bus.rsp0_rdata, bus.rsp1_rdata);
    end
    bus.rq0_valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_store_load();
    bit ok;
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL st_grant: got %b want 1", ok); end
    n_cmp++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wd} !== {1'b1, 32'h10, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL st_access: got we=%b addr=%h wd=%h want we=1 addr=00000010 wd=deadbeef",
               bus.mem_we, bus.mem_addr, bus.mem_wd);
    end
    step();
    n_cmp++;
    if ({bus.rsp0_valid, bus.rsp0_err, bus.rsp1_valid, bus.mem_we, bus.rsp0_rdata} !==
        {4'b1000, 32'h0}) begin
      n_bad++;
      $display("FAIL st_resp: got v0=%b e0=%b v1=%b we=%b rd=%h want 1 0 0 0 0",
               bus.rsp0_valid, bus.rsp0_err, bus.rsp1_valid, bus.mem_we, bus.rsp0_rdata);
    end
    release_rsp(0);
    n_cmp++;
    if (bus.rsp0_valid !== 1'b0) begin
      n_bad++; $display("FAIL st_release: rsp0_valid got %b want 0", bus.rsp0_valid);
    end

    issue(1, 1'b0, 32'h10, 32'h0, ok);
    n_cmp++;
    if ({ok, bus.mem_we} !== 2'b10) begin
      n_bad++; $display("FAIL ld_access: got ok/we=%b%b want 10", ok, bus.mem_we);
    end
    step();
    n_cmp++;
    if ({bus.rsp1_valid, bus.rsp1_err, bus.rsp0_valid, bus.rsp1_rdata} !== {3'b100, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL ld_resp: got v1=%b e1=%b v0=%b rd=%h want 1 0 0 deadbeef",
               bus.rsp1_valid, bus.rsp1_err, bus.rsp0_valid, bus.rsp1_rdata);
    end
    release_rsp(1);
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    bus.rq0_we = 1'b0; bus.rq0_addr = 32'h10; bus.rq0_wdata = 32'h0; bus.rq0_pc = 32'h300;
    bus.rq1_we = 1'b0; bus.rq1_addr = 32'h10; bus.rq1_wdata = 32'h0; bus.rq1_pc = 32'h400;
    bus.rq0_valid = 1'b1; bus.rq1_valid = 1'b1;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++;
      if ({bus.rq1_ready, bus.rq0_ready} !== exp_g) begin
        n_bad++;
        $display("FAIL rr_grant%0d: got %b want %b", k, {bus.rq1_ready, bus.rq0_ready}, exp_g);
      end
      step();
      n_cmp++;
      if ({bus.rq1_ready, bus.rq0_ready, bus.mem_we} !== 3'b000) begin
        n_bad++;
        $display("FAIL rr_access%0d: got rdy=%b we=%b want 00 0", k,
                 {bus.rq1_ready, bus.rq0_ready}, bus.mem_we);
      end
      step();
      n_cmp++;
      if ({bus.rq1_ready, bus.rq0_ready, bus.rsp1_valid, bus.rsp0_valid} !== {2'b00, exp_g}) begin
        n_bad++;
        $display("FAIL rr_resp%0d: got rdy=%b rsp=%b want 00 %b", k,
                 {bus.rq1_ready, bus.rq0_ready}, {bus.rsp1_valid, bus.rsp0_valid}, exp_g);
      end
      n_cmp++;
      if ((bus.rsp0_rdata | bus.rsp1_rdata) !== 32'hDEADBEEF) begin
        n_bad++;
        $display("FAIL rr_rdata%0d: got %h want deadbeef", k, bus.rsp0_rdata | bus.rsp1_rdata);
      end
      step();
    end
    bus.rq0_valid = 1'b0; bus.rq1_valid = 1'b0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    step();
  endtask

  task automatic test_errors();
    bit ok;
    logic [31:0] t_addr  [4];
    logic        t_we    [4];
    logic        t_err   [4];
    logic [31:0] t_rdata [4];
    t_addr  = '{32'h13, 32'h3000, 32'h0001_0000, 32'h2FFC};
    t_we    = '{1'b1, 1'b0, 1'b0, 1'b0};
    t_err   = '{1'b1, 1'b1, 1'b1, 1'b0};
    t_rdata = '{32'h0, 32'h0, 32'h0, 32'hCAFEF00D};
    // Last in-range word, written so the boundary load has a known value.
    issue(1, 1'b1, 32'h2FFC, 32'hCAFEF00D, ok);
    step();
    release_rsp(1);
    for (int k = 0; k < 4; k++) begin
      issue(0, t_we[k], t_addr[k], 32'h55, ok);
      n_cmp++;
      if ({ok, bus.mem_we} !== 2'b10) begin
        n_bad++;
        $display("FAIL err_access%0d: got ok/we=%b%b want 10", k, ok, bus.mem_we);
      end
      step();
      n_cmp++;
      if ({bus.rsp0_valid, bus.rsp0_err, bus.rsp0_rdata} !== {1'b1, t_err[k], t_rdata[k]}) begin
        n_bad++;
        $display("FAIL err_resp%0d: got v=%b e=%b rd=%h want 1 %b %h", k,
                 bus.rsp0_valid, bus.rsp0_err, bus.rsp0_rdata, t_err[k], t_rdata[k]);
      end
      release_rsp(0);
    end
    // The misaligned store must not have touched word 4.
    issue(1, 1'b0, 32'h10, 32'h0, ok);
    step();
    n_cmp++;
    if (bus.rsp1_rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL err_nowrite: got %h want deadbeef", bus.rsp1_rdata);
    end
    release_rsp(1);
  endtask

  task automatic test_backpressure();
    bit ok;
    issue(0, 1'b0, 32'h10, 32'h0, ok);
    step();
    bus.rq1_we = 1'b0; bus.rq1_addr = 32'h10; bus.rq1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if ({bus.rsp0_valid, bus.rsp0_rdata, bus.rq0_ready, bus.rq1_ready} !==
          {1'b1, 32'hDEADBEEF, 2'b00}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v=%b rd=%h rdy=%b%b want 1 deadbeef 00", k,
                 bus.rsp0_valid, bus.rsp0_rdata, bus.rq0_ready, bus.rq1_ready);
      end
      step();
    end
    release_rsp(0);
    n_cmp++;
    if ({bus.rsp0_valid, bus.rq1_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_release: got v0/rdy1=%b%b want 01", bus.rsp0_valid, bus.rq1_ready);
    end
    bus.rq1_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    issue(1, 1'b1, 32'h20, 32'h11111111, ok);
    step();
    release_rsp(1);
    issue(0, 1'b1, 32'h20, 32'h22222222, ok);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_we !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_we: got %b want 0", bus.mem_we);
    end
    step();
    n_cmp++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wd, bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata} !==
        {1'b0, 64'h0, 2'b00, 32'h0}) begin
      n_bad++;
      $display("FAIL rstmid_outs: got we=%b a=%h wd=%h v=%b%b rd=%h want all 0", bus.mem_we,
               bus.mem_addr, bus.mem_wd, bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata);
    end
    rst = 1'b0;
    step();
    issue(0, 1'b0, 32'h20, 32'h0, ok);
    step();
    n_cmp++;
    if ({ok, bus.rsp0_valid, bus.rsp0_rdata} !== {2'b11, 32'h11111111}) begin
      n_bad++;
      $display("FAIL rstmid_old: got ok=%b v=%b rd=%h want 1 1 11111111", ok,
               bus.rsp0_valid, bus.rsp0_rdata);
    end
    release_rsp(0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.rq0_valid = 1'b0; bus.rq0_we = 1'b0; bus.rq0_addr = '0; bus.rq0_wdata = '0; bus.rq0_pc = '0;
    bus.rq1_valid = 1'b0; bus.rq1_we = 1'b0; bus.rq1_addr = '0; bus.rq1_wdata = '0; bus.rq1_pc = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    test_reset();
    test_store_load();
    test_contention();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port word-addressed data memory.
- Shares the memory between requester 0 (CPU load/store path) and requester 1 (DMA or debug/init port).
- Captures one request, drives the memory port for exactly one cycle, then returns a registered response with valid/ready handshake.
- Rejects misaligned or out-of-range accesses without touching memory.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words in the memory; word index is addr[13:2].
- RST_LAST, 1, reset value of the last-grant pointer, so requester 0 wins the first tie.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- rq0_valid / rq1_valid  input  1  request present.
- rq0_ready / rq1_ready  output  1  request accepted this cycle.
- rq0_we / rq1_we  input  1  1 = store, 0 = load.
- rq0_addr / rq1_addr  input  32  byte address.
- rq0_wdata / rq1_wdata  input  32  store data.
- rq0_pc / rq1_pc  input  32  issuing PC, used for trace only.
- rsp0_valid / rsp1_valid  output  1  response available.
- rsp0_ready / rsp1_ready  input  1  response consumed.
- rsp0_rdata / rsp1_rdata  output  32  load data; 0 for stores and errors.
- rsp0_err / rsp1_err  output  1  misaligned or out-of-range.
- mem_addr  output  32  byte address to memory.
- mem_wd  output  32  write data to memory.
- mem_we  output  1  write strobe, one cycle wide.
- mem_rd  input  32  combinational read data from memory.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset: state=IDLE, last_grant=RST_LAST, and every output is 0 (all rqN_ready, rspN_valid, rspN_rdata, rspN_err, mem_addr, mem_wd, mem_we). Reset mid-transaction discards the captured request and any pending response; no write is issued.
- IDLE:
  - Grant is combinational from the valids.
  - With one valid, that requester is granted.
  - With both valid, grant the requester != last_grant.
  - rqN_ready=1 only for the granted requester, and only in IDLE.
  - On handshake: capture id, we, addr, wdata, pc; set last_grant=id; go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr = captured addr.
  - mem_wd = captured wdata.
  - mem_we = captured we & ~err.
  - err = (addr[1:0] != 0) | (addr[13:2] >= DEPTH_WORDS) | (addr[31:14] != 0).
  - Load data: mem_rd is registered into the response data, or 0 for stores and errors.
  - Go to RESP.
- RESP:
  - rsp<id>_valid=1 with rdata/err stable until rsp<id>_ready=1 is sampled; then return to IDLE.
  - The other requester's rsp stays 0.
- Latency: handshake in cycle T -> mem_we in T+1 -> rsp_valid from T+2. Minimum 3 cycles per transaction.
- Outside ACCESS: mem_we=0. mem_addr and mem_wd hold their last value.
- A requester may drop valid before it is granted; no request is lost or duplicated.
- Strict alternation under continuous contention: 0,1,0,1...
- Store-then-load to the same address from different requesters: the load sees the new data, because transactions are serialized.

Optional Feature:
- Macro: DM_ARB_TRACE_EN.
- Defined: in ACCESS with mem_we=1, print via $display "@%h: *%h <= %h" using pc, addr, wdata. Error accesses print "@%h: DM err %h".
- Undefined: no $display; behaviour otherwise identical.

Decomposition:
- Package dm_arb_pkg holds:
  - state enum (IDLE, ACCESS, RESP);
  - requester-id type (1 bit);
  - localparams for the word-index field (WIDX_HI=13, WIDX_LO=2).
- Sub-module rr_arb2: pure combinational 2-way round-robin grant from valid[1:0] and last_grant, producing a one-hot grant.

Test Plan:
- Reset, then rq0 store addr=0x10, wdata=0xDEADBEEF -> mem_we=1 at T+1 with mem_addr=0x10; rsp0_valid at T+2, rsp0_err=0.
- rq1 load addr=0x10 after the above -> rsp1_rdata=0xDEADBEEF, rsp1_err=0.
- Both valid continuously for 4 transactions -> grants 0,1,0,1; no rq*_ready while in ACCESS or RESP.
- rq0 store addr=0x13 (misaligned) and rq0 load addr=0x3000 (index 3072) -> mem_we stays 0, rsp0_err=1, rsp0_rdata=0.
- rsp0_ready held 0 for 5 cycles -> rsp0_valid and rsp0_rdata stable, new requests not accepted; release -> IDLE next cycle.
- rst asserted during ACCESS of a store -> mem_we=0 and all outputs 0 the next cycle; a following load of that address returns the old value.
